alu_mul_seq: RTL
================

# alu_mul_seq

Multi-cycle 32-bit multiply sequencer that implements RV32M `MUL` (low 32 bits of the product) by reusing the shared ALU adder rather than instantiating a multiplier. It sits beside the ALU in the execute stage. It accepts operands with a start/busy handshake and runs a shift-and-add loop, driving the ALU operand and control inputs each cycle. It returns the product with a one-cycle `done` pulse. While the sequencer is busy, the ALU input mux selects its `alu_srca`/`alu_srcb`/`alu_ctrl`.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `start`  in  1  request; accepted only in IDLE.
- `flush`  in  1  synchronous abort; returns to IDLE, no `done`.
- `op_a`  in  32  multiplicand; sampled on accepted start.
- `op_b`  in  32  multiplier; sampled on accepted start.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  32  product[31:0]; held until the next accepted start.
- `alu_srca`  out  32  ALU SrcA drive.
- `alu_srcb`  out  32  ALU SrcB drive.
- `alu_ctrl`  out  3  ALU control; always 3'b000 (add).
- `alu_sel`  out  1  high in CALC; steers the ALU input mux to this block.
- `alu_result`  in  32  ALU output, combinational from the drives above.

## Operation
- **Registers:**
  - `acc` (32) is the accumulator and drives `result`.
  - `mcand` (32) holds the multiplicand.
  - `mplr` (32) holds the multiplier.
  - `state` is one of {IDLE, CALC, DONE}.
- **IDLE:**
  - On `start` high: `acc` <= 0, `mcand` <= `op_a`, `mplr` <= `op_b`, go to CALC.
  - Otherwise hold.
- **CALC, each cycle:**
  - Drive `alu_srca` = `acc` and `alu_srcb` = `mcand`.
  - If `mplr[0]`, `acc` <= `alu_result`; else `acc` holds.
  - `mcand` <= `mcand` << 1 and `mplr` <= `mplr` >> 1, both logical and done internally (not via the ALU).
  - If (`mplr` >> 1) == 0, go to DONE; else stay in CALC.
- **DONE:**
  - `done` = 1 for this cycle.
  - Next cycle go to IDLE.
- **Outside CALC:** `alu_srca`/`alu_srcb` = 0, `alu_ctrl` = 3'b000, `alu_sel` = 0.
- **Arithmetic:**
  - All sums wrap modulo 2^32; carries out are discarded.
  - The low 32 bits are identical for signed and unsigned operands, so there is no sign handling.
  - `alu_zero` is not used.
- **`start` while `busy`:** ignored; no queueing, operands not sampled.
- **`flush`:**
  - Has priority over all transitions. From any state go to IDLE next edge.
  - `done` is suppressed. `acc` (and so `result`) keeps its partial value and is not valid.
  - `flush` and `start` high together in IDLE: flush wins, start is dropped.
- **`reset` (asynchronous, any time, including mid-CALC):**
  - `state` = IDLE.
  - `acc` = `mcand` = `mplr` = 0.

## Timing
- **Reset values:** `busy` = 0, `done` = 0, `result` = 0, `alu_sel` = 0, `alu_srca` = `alu_srcb` = 0, `alu_ctrl` = 3'b000.
- **Start:** sampled at edge E in IDLE; CALC occupies cycles E+1 … E+k.
- **CALC length:** k = max(1, position of the MSB of `op_b` + 1), so k ranges over 1..32.
  - `op_b` = 0 gives k = 1.
  - `op_b` with bit 31 set gives k = 32.
- **Done:** `done` is high in cycle E+k+1 and `result` is stable from that cycle onward.
- **Busy window:** `busy` is high from E+1 through E+k+1 and low at E+k+2.
- **Back-to-back:** the earliest next accepted start is at edge E+k+2, i.e. a start sampled in the first IDLE cycle.
- **Outputs:**
  - `busy`, `done` and `alu_sel` decode from registered state only, with no combinational path from `start`.
  - `alu_srca`/`alu_srcb` come from registers.
- **Critical path:** `alu_result` → `acc` D input, i.e. the ALU adder plus a 2:1 mux, within one cycle.

## Test plan
- **Small operands:** `op_a` = 7, `op_b` = 6.
  - Exactly 3 CALC cycles.
  - `done` at E+4 with `result` = 42.
  - `busy` low at E+5.
- **Full-width wrap:** 0xFFFFFFFF × 0xFFFFFFFF.
  - 32 CALC cycles, `done` at E+33.
  - `result` = 0x00000001.
  - `alu_ctrl` = 000 throughout.
- **Zero multiplier and overflow:**
  - 0x12345678 × 0 → 1 CALC cycle, `result` = 0.
  - 0x80000000 × 2 → `result` = 0 (wrap).
- **Start while busy:** 3 × 5 started; a second `start` with 9 × 9 is pulsed mid-CALC.
  - The second start is ignored.
  - `result` = 15 with a single `done`.
  - A new start issued in the first IDLE cycle is accepted and returns 81.
- **Flush:** `flush` asserted in CALC cycle 2 of 0xFFFF × 0xFFFF.
  - IDLE on the next edge.
  - No `done` pulse.
  - `busy` = 0 on the cycle after the flush edge.
  - A subsequent 2 × 3 returns 6.
- **Async reset mid-CALC:** assert `reset` between clock edges during a CALC.
  - `busy`, `done`, `alu_sel` and `result` go to 0 immediately.
  - After release, 10 × 10 returns 100.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Multi-cycle RV32M MUL sequencer: shift-and-add loop that borrows the shared ALU adder.
// Returns product[31:0] with a one-cycle done pulse; flush aborts without done.
module alu_mul_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic [31:0] o_alu_srca,
  output logic [31:0] o_alu_srcb,
  output logic [2:0]  o_alu_ctrl,
  output logic        o_alu_sel,
  input  logic [31:0] i_alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplr;
  logic        r_busy;
  logic        r_done;
  logic        r_sel;

  // Sequencer state, datapath registers and registered handshake outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_acc   <= 32'd0;
      r_mcand <= 32'd0;
      r_mplr  <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sel   <= 1'b0;
    end else if (i_flush) begin
      // acc keeps its partial value; result is simply not flagged valid
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= CALC;
            r_acc   <= 32'd0;
            r_mcand <= i_op_a;
            r_mplr  <= i_op_b;
            r_busy  <= 1'b1;
            r_sel   <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
            r_sel   <= 1'b0;
          end
        end
        CALC: begin
          if (r_mplr[0]) begin
            r_acc <= i_alu_result;
          end
          r_mcand <= {r_mcand[30:0], 1'b0};
          r_mplr  <= {1'b0, r_mplr[31:1]};
          if (r_mplr[31:1] == 31'd0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_sel   <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_sel   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_sel   <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_alu_sel  = r_sel;
  assign o_result   = r_acc;
  assign o_alu_ctrl = 3'b000;
  assign o_alu_srca = r_sel ? r_acc   : 32'd0;
  assign o_alu_srcb = r_sel ? r_mcand : 32'd0;

endmodule
